// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data bits LSB first, odd parity, stop, ack.
// Optional single retry on NACK/timeout when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int IDLE_CYCLES    = 2500
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic       o_ps2_clk_oe,
   output logic       o_ps2_dat_oe
);

   // state    | meaning
   // IDLE     | ready for a request, lines released
   // INHIBIT  | hold clock low; data pulled low in the final cycle
   // START    | start bit on the line, waiting for first device clock
   // DATA     | shifting d[0..7] out on device falling edges
   // PARITY   | parity bit on the line
   // STOP     | line released as stop bit
   // ACK_WAIT | ack seen, waiting for the bus to go idle
   // DONE     | one-cycle success pulse
   // ERR      | one-cycle failure pulse (NACK or timeout)
   typedef enum logic [3:0] {
      S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_STOP, S_ACK_WAIT, S_DONE, S_ERR
   } state_t;

   localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int IW   = $clog2(IDLE_CYCLES + 1);
   localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_LOAD    = IW'(IDLE_CYCLES - 1);

   state_t          state, state_nxt;
   logic [7:0]      data_q, data_nxt;
   logic [3:0]      bit_cnt, bit_cnt_nxt;
   logic            tx_oe_q, tx_oe_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [IW-1:0]   idle_cnt, idle_nxt;
   logic            clk_s1, clk_s2, clk_s3;
   logic            dat_s1, dat_s2, dat_s3;
   logic            fe_q;
   logic            timer_zero;
   logic            fail;
`ifdef PS2_TX_RETRY_EN
   logic            retry_used, retry_nxt;
`endif

   // Sync flops idle high so that reset release never looks like a falling edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
         dat_s3 <= 1'b1;
         fe_q   <= 1'b0;
      end else begin
         clk_s1 <= i_ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= i_ps2_dat;
         dat_s2 <= dat_s1;
         dat_s3 <= dat_s2;
         fe_q   <= clk_s3 & ~clk_s2;
      end
   end

   assign timer_zero = (timer == '0);

   always_comb begin
      state_nxt   = state;
      data_nxt    = data_q;
      bit_cnt_nxt = bit_cnt;
      tx_oe_nxt   = tx_oe_q;
      timer_nxt   = timer;
      idle_nxt    = idle_cnt;
      fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_nxt   = retry_used;
`endif
      case (state)
         S_IDLE: begin
            if (i_valid) begin
               data_nxt    = i_data;
               bit_cnt_nxt = 4'd0;
               timer_nxt   = INHIBIT_LOAD;
               state_nxt   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_nxt   = 1'b0;
`endif
            end
         end
         S_INHIBIT: begin
            if (timer_zero) begin
               timer_nxt = TIMEOUT_LOAD;
               state_nxt = S_START;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_START: begin
            if (fe_q) begin
               timer_nxt   = TIMEOUT_LOAD;
               tx_oe_nxt   = ~data_q[0];
               bit_cnt_nxt = 4'd1;
               state_nxt   = S_DATA;
            end else if (timer_zero) begin
               fail = 1'b1;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_DATA: begin
            if (fe_q) begin
               timer_nxt = TIMEOUT_LOAD;
               if (bit_cnt == 4'd8) begin
                  // Odd parity bit is ~^data, so the pull-down is its inverse.
                  tx_oe_nxt = ^data_q;
                  state_nxt = S_PARITY;
               end else begin
                  tx_oe_nxt   = ~data_q[bit_cnt[2:0]];
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end else if (timer_zero) begin
               fail = 1'b1;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_PARITY: begin
            if (fe_q) begin
               timer_nxt = TIMEOUT_LOAD;
               tx_oe_nxt = 1'b0;
               state_nxt = S_STOP;
            end else if (timer_zero) begin
               fail = 1'b1;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_STOP: begin
            if (fe_q) begin
               timer_nxt = TIMEOUT_LOAD;
               if (dat_s3) begin
                  fail = 1'b1;
               end else begin
                  idle_nxt  = IDLE_LOAD;
                  state_nxt = S_ACK_WAIT;
               end
            end else if (timer_zero) begin
               fail = 1'b1;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_ACK_WAIT: begin
            if (timer_zero) begin
               fail = 1'b1;
            end else begin
               timer_nxt = timer - TW'(1);
               if (clk_s3 && dat_s3) begin
                  if (idle_cnt == '0) state_nxt = S_DONE;
                  else                idle_nxt  = idle_cnt - IW'(1);
               end else begin
                  idle_nxt = IDLE_LOAD;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      if (fail) begin
`ifdef PS2_TX_RETRY_EN
         if (!retry_used) begin
            retry_nxt   = 1'b1;
            bit_cnt_nxt = 4'd0;
            tx_oe_nxt   = 1'b0;
            timer_nxt   = INHIBIT_LOAD;
            state_nxt   = S_INHIBIT;
         end else begin
            state_nxt = S_ERR;
         end
`else
         state_nxt = S_ERR;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         data_q   <= 8'h00;
         bit_cnt  <= 4'd0;
         tx_oe_q  <= 1'b0;
         timer    <= '0;
         idle_cnt <= '0;
`ifdef PS2_TX_RETRY_EN
         retry_used <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         data_q   <= data_nxt;
         bit_cnt  <= bit_cnt_nxt;
         tx_oe_q  <= tx_oe_nxt;
         timer    <= timer_nxt;
         idle_cnt <= idle_nxt;
`ifdef PS2_TX_RETRY_EN
         retry_used <= retry_nxt;
`endif
      end
   end

   // Outputs decode from state so an async reset releases both lines at once.
   always_comb begin
      o_ready      = (state == S_IDLE);
      o_busy       = (state != S_IDLE);
      o_done       = (state == S_DONE);
      o_error      = (state == S_ERR);
      o_ps2_clk_oe = (state == S_INHIBIT);
      case (state)
         S_INHIBIT:       o_ps2_dat_oe = timer_zero;
         S_START:         o_ps2_dat_oe = 1'b1;
         S_DATA, S_PARITY: o_ps2_dat_oe = tx_oe_q;
         default:         o_ps2_dat_oe = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model clocking at a 40-cycle period.
module tb_ps2_host_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic       valid;
   logic       ready, busy, done, error;
   logic       clk_oe, dat_oe;
   logic       dev_clk, dev_dat;
   logic       ps2_clk, ps2_dat;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   assign ps2_clk = dev_clk & ~clk_oe;
   assign ps2_dat = dev_dat & ~dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(20),
      .TIMEOUT_CYCLES(400),
      .IDLE_CYCLES(10)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_data(data),
      .i_valid(valid),
      .o_ready(ready),
      .o_busy(busy),
      .o_done(done),
      .o_error(error),
      .i_ps2_clk(ps2_clk),
      .i_ps2_dat(ps2_dat),
      .o_ps2_clk_oe(clk_oe),
      .o_ps2_dat_oe(dat_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) err_cnt++;
      if (done === 1'b1 && error === 1'b1) both_cnt++;
   end

   task automatic start_req(input logic [7:0] b);
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic count_inhibit(output int n, output logic last_dat);
      n = 0;
      last_dat = 1'b0;
      while (clk_oe === 1'b1 && n < 100) begin
         last_dat = dat_oe;
         n++;
         @(negedge clk);
      end
   endtask

   // Device clocks; dat_oe is sampled at each device rising edge.
   task automatic device_run(input int nclk, output logic [9:0] smp);
      smp = '0;
      repeat (5) @(negedge clk);
      for (int k = 0; k < nclk; k++) begin
         dev_clk = 1'b0;
         repeat (20) @(negedge clk);
         dev_clk = 1'b1;
         smp[k] = dat_oe;
         repeat (20) @(negedge clk);
      end
   endtask

   task automatic device_ack_and_wait(output int n);
      dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ready, busy, done, error, clk_oe, dat_oe} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_state got=%b exp=100000", {ready, busy, done, error, clk_oe, dat_oe});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_f4_ack;
      int n, d0, e0;
      logic last;
      logic [9:0] smp;
      d0 = done_cnt;
      e0 = err_cnt;
      start_req(8'hF4);
      count_inhibit(n, last);
      checks++;
      if (n !== 20) begin
         failures++;
         $display("FAIL f4_inhibit_len got=%0d exp=20", n);
      end
      checks++;
      if (last !== 1'b1) begin
         failures++;
         $display("FAIL f4_inhibit_last_dat got=%b exp=1", last);
      end
      checks++;
      if ({clk_oe, dat_oe} !== 2'b01) begin
         failures++;
         $display("FAIL f4_start_bit got=%b exp=01", {clk_oe, dat_oe});
      end
      device_run(10, smp);
      checks++;
      if (smp !== 10'b0100001011) begin
         failures++;
         $display("FAIL f4_frame_bits got=%b exp=0100001011", smp);
      end
      device_ack_and_wait(n);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL f4_done_seen got=%b exp=1", done);
      end
      @(negedge clk);
      #1;
      checks++;
      if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0 || busy !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL f4_post done=%0d err=%0d busy=%b ready=%b exp=1 0 0 1",
                  done_cnt - d0, err_cnt - e0, busy, ready);
      end
   endtask

   task automatic test_zero_parity;
      int n, d0;
      logic last;
      logic [9:0] smp;
      d0 = done_cnt;
      start_req(8'h00);
      count_inhibit(n, last);
      device_run(10, smp);
      checks++;
      if (smp !== 10'b0011111111) begin
         failures++;
         $display("FAIL zero_frame_bits got=%b exp=0011111111", smp);
      end
      checks++;
      if (smp[8] !== 1'b0) begin
         failures++;
         $display("FAIL zero_parity_oe got=%b exp=0", smp[8]);
      end
      device_ack_and_wait(n);
      @(negedge clk);
      #1;
      checks++;
      if ((done_cnt - d0) !== 1) begin
         failures++;
         $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0);
      end
   endtask

   task automatic test_nack;
      int n, d0, e0;
      logic last;
      logic [9:0] smp;
      d0 = done_cnt;
      e0 = err_cnt;
      start_req(8'hFF);
      count_inhibit(n, last);
      device_run(10, smp);
      checks++;
      if (smp !== 10'b0000000000) begin
         failures++;
         $display("FAIL ff_frame_bits got=%b exp=0000000000", smp);
      end
      dev_clk = 1'b0;
      n = 0;
      while (error !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (error !== 1'b1) begin
         failures++;
         $display("FAIL nack_error_seen got=%b exp=1", error);
      end
      checks++;
      if ({done, clk_oe, dat_oe} !== 3'b000) begin
         failures++;
         $display("FAIL nack_lines got=%b exp=000", {done, clk_oe, dat_oe});
      end
      @(negedge clk);
      checks++;
      if ({error, ready} !== 2'b01) begin
         failures++;
         $display("FAIL nack_next_cycle got=%b exp=01", {error, ready});
      end
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
         failures++;
         $display("FAIL nack_counts err=%0d done=%0d exp=1 0", err_cnt - e0, done_cnt - d0);
      end
   endtask

   task automatic test_timeout;
      int n;
      logic last;
      start_req(8'hF4);
      count_inhibit(n, last);
      n = 0;
      while (error !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < 399 || n > 401) begin
         failures++;
         $display("FAIL timeout_latency got=%0d exp=400", n);
      end
      checks++;
      if ({error, clk_oe, dat_oe} !== 3'b100) begin
         failures++;
         $display("FAIL timeout_lines got=%b exp=100", {error, clk_oe, dat_oe});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe;
      int n;
      logic last;
      logic [9:0] smp;
      start_req(8'hF4);
      count_inhibit(n, last);
      device_run(4, smp);
      checks++;
      if (smp[3:0] !== 4'b1011) begin
         failures++;
         $display("FAIL midrst_bits got=%b exp=1011", smp[3:0]);
      end
      checks++;
      if (dat_oe !== 1'b1) begin
         failures++;
         $display("FAIL midrst_pre_dat got=%b exp=1", dat_oe);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({clk_oe, dat_oe, busy} !== 3'b000) begin
         failures++;
         $display("FAIL midrst_async_release got=%b exp=000", {clk_oe, dat_oe, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL midrst_after got=%b exp=10", {ready, busy});
      end
   endtask

   task automatic test_ignore_busy;
      int n, d0;
      logic last;
      logic [9:0] smp;
      d0 = done_cnt;
      start_req(8'hF4);
      data  = 8'h55;
      valid = 1'b1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL busy_ready got=%b exp=0", ready);
      end
      count_inhibit(n, last);
      valid = 1'b0;
      checks++;
      if (n !== 19) begin
         failures++;
         $display("FAIL busy_inhibit_rest got=%0d exp=19", n);
      end
      device_run(10, smp);
      checks++;
      if (smp !== 10'b0100001011) begin
         failures++;
         $display("FAIL busy_frame_bits got=%b exp=0100001011", smp);
      end
      device_ack_and_wait(n);
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if ((done_cnt - d0) !== 1 || busy !== 1'b0 || clk_oe !== 1'b0) begin
         failures++;
         $display("FAIL busy_no_requeue done=%0d busy=%b clk_oe=%b exp=1 0 0",
                  done_cnt - d0, busy, clk_oe);
      end
   endtask

`ifdef PS2_TX_RETRY_EN
   task automatic test_retry;
      int n, d0, e0;
      logic last;
      logic [9:0] smp;
      d0 = done_cnt;
      e0 = err_cnt;
      start_req(8'hF4);
      count_inhibit(n, last);
      device_run(10, smp);
      dev_clk = 1'b0;
      n = 0;
      while (clk_oe !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (clk_oe !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL retry_second_inhibit clk_oe=%b busy=%b exp=1 1", clk_oe, busy);
      end
      dev_clk = 1'b1;
      count_inhibit(n, last);
      checks++;
      if (n !== 20) begin
         failures++;
         $display("FAIL retry_inhibit_len got=%0d exp=20", n);
      end
      device_run(10, smp);
      checks++;
      if (smp !== 10'b0100001011) begin
         failures++;
         $display("FAIL retry_frame_bits got=%b exp=0100001011", smp);
      end
      device_ack_and_wait(n);
      @(negedge clk);
      #1;
      checks++;
      if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
         failures++;
         $display("FAIL retry_counts done=%0d err=%0d exp=1 0", done_cnt - d0, err_cnt - e0);
      end
   endtask
`endif

   task automatic test_exclusive_pulses;
      checks++;
      if (both_cnt !== 0) begin
         failures++;
         $display("FAIL done_error_overlap got=%0d exp=0", both_cnt);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      data    = 8'h00;
      valid   = 1'b0;
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      test_reset;
      test_f4_ack;
      test_zero_parity;
`ifdef PS2_TX_RETRY_EN
      test_retry;
`else
      test_nack;
      test_timeout;
`endif
      test_reset_midframe;
      test_ignore_busy;
      test_exclusive_pulses;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
